// File: rtl/serial_sub_if.sv
// Start/busy/done handshake bundle for the bit-serial subtractor.
// The master side issues operands; the slave side returns the difference and flags.
interface serial_sub_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             B_out;
    logic             O_sub;

    modport master (
        output start, A, B,
        input  busy, done, D, B_out, O_sub
    );

    modport slave (
        input  start, A, B,
        output busy, done, D, B_out, O_sub
    );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial two's-complement subtractor D = A - B, LSB first, one bit per clock.
// Results and flags are held from one completion until the next or until reset.
module serial_sub #(
    parameter int unsigned WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    serial_sub_if.slave  bus
);
    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [WIDTH-1:0] a_sh_q, a_sh_n;
    logic [WIDTH-1:0] b_sh_q, b_sh_n;
    logic [WIDTH-1:0] res_q, res_n;
    logic             borrow_q, borrow_n;
    logic [WIDTH-1:0] d_q, d_n;
    logic             bout_q, bout_n;
    logic             osub_q, osub_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;

    logic a_bit, b_bit, d_bit, bo_bit;

    // Full-subtractor cell on the current LSBs.
    always_comb begin
        a_bit  = a_sh_q[0];
        b_bit  = b_sh_q[0];
        d_bit  = a_bit ^ b_bit ^ borrow_q;
        bo_bit = (~a_bit & b_bit) | (~a_bit & borrow_q) | (b_bit & borrow_q);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        a_sh_n   = a_sh_q;
        b_sh_n   = b_sh_q;
        res_n    = res_q;
        borrow_n = borrow_q;
        d_n      = d_q;
        bout_n   = bout_q;
        osub_n   = osub_q;
        busy_n   = 1'b0;
        done_n   = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_n  = SHIFT;
                    a_sh_n   = bus.A;
                    b_sh_n   = bus.B;
                    borrow_n = 1'b0;
                    cnt_n    = '0;
                    busy_n   = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            SHIFT: begin
                res_n    = {d_bit, res_q[WIDTH-1:1]};
                borrow_n = bo_bit;
                a_sh_n   = a_sh_q >> 1;
                b_sh_n   = b_sh_q >> 1;
                if (cnt_q == LAST) begin
                    // Borrow into the MSB is still in borrow_q here, so overflow is bin ^ bout.
                    state_n = DONE;
                    cnt_n   = '0;
                    done_n  = 1'b1;
                    d_n     = {d_bit, res_q[WIDTH-1:1]};
                    bout_n  = bo_bit;
                    osub_n  = borrow_q ^ bo_bit;
                end else begin
                    cnt_n  = cnt_q + CNT_W'(1);
                    busy_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            d_q      <= '0;
            bout_q   <= 1'b0;
            osub_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            a_sh_q   <= a_sh_n;
            b_sh_q   <= b_sh_n;
            res_q    <= res_n;
            borrow_q <= borrow_n;
            d_q      <= d_n;
            bout_q   <= bout_n;
            osub_q   <= osub_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.D     = d_q;
    assign bus.B_out = bout_q;
    assign bus.O_sub = osub_q;
endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: directed vectors, handshake corner cases
// and randomized operands against an arithmetic reference model.
module tb_serial_sub;
    localparam int unsigned W = 4;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    logic [W-1:0] exp_d_last;
    logic         exp_b_last;
    logic         exp_o_last;

    serial_sub_if #(.WIDTH(W)) bus ();

    serial_sub #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the operand values.
    function automatic void ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] d, output logic bo, output logic ov);
        int ua, ub, sa, sb, diff;
        ua   = int'(a);
        ub   = int'(b);
        sa   = a[W-1] ? ua - (1 << W) : ua;
        sb   = b[W-1] ? ub - (1 << W) : ub;
        diff = sa - sb;
        d    = W'((ua - ub) & ((1 << W) - 1));
        bo   = (ua < ub);
        ov   = (diff > (1 << (W - 1)) - 1) || (diff < -(1 << (W - 1)));
    endfunction

    // One operation with full timing/result checks. noise: 0 quiet, 1 directed start pulse
    // during busy, 2 random start/operand churn during busy. b2b: start in current cycle.
    task automatic test_op(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int noise, input bit b2b, input string name);
        logic [W-1:0] ed;
        logic         eb, eo;
        ref_sub(a, b, ed, eb, eo);
        if (!b2b) @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < int'(W); i++) begin
            checks++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL %s busy cycle %0d: busy=%b done=%b, required busy=1 done=0",
                         name, i, bus.busy, bus.done);
            end
            checks++;
            if (bus.D !== exp_d_last || bus.B_out !== exp_b_last || bus.O_sub !== exp_o_last) begin
                errors++;
                $display("FAIL %s hold cycle %0d: D=%b B_out=%b O_sub=%b, required %b %b %b",
                         name, i, bus.D, bus.B_out, bus.O_sub, exp_d_last, exp_b_last, exp_o_last);
            end
            if (noise == 1) begin
                bus.start = (i == 1);
                if (i == 1) begin
                    bus.A = 4'b1111;
                    bus.B = 4'b0001;
                end
            end else if (noise == 2) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.A     = W'($urandom);
                bus.B     = W'($urandom);
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done cycle: done=%b busy=%b, required done=1 busy=0",
                     name, bus.done, bus.busy);
        end
        checks++;
        if (bus.D !== ed || bus.B_out !== eb || bus.O_sub !== eo) begin
            errors++;
            $display("FAIL %s result A=%b B=%b: D=%b B_out=%b O_sub=%b, required %b %b %b",
                     name, a, b, bus.D, bus.B_out, bus.O_sub, ed, eb, eo);
        end
        exp_d_last = ed;
        exp_b_last = eb;
        exp_o_last = eo;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.D !== '0 ||
            bus.B_out !== 1'b0 || bus.O_sub !== 1'b0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b D=%b B_out=%b O_sub=%b, required all zero",
                     bus.busy, bus.done, bus.D, bus.B_out, bus.O_sub);
        end
        exp_d_last = '0;
        exp_b_last = 1'b0;
        exp_o_last = 1'b0;
    endtask

    task automatic test_directed();
        test_op(4'b0101, 4'b0011, 0, 1'b0, "vec1");
        test_op(4'b0011, 4'b0101, 0, 1'b0, "vec2");
        test_op(4'b0111, 4'b1000, 0, 1'b0, "vec3");
        test_op(4'b1000, 4'b0001, 0, 1'b0, "vec4");
        checks++;
        if (bus.D !== 4'b0111 || bus.B_out !== 1'b0 || bus.O_sub !== 1'b1) begin
            errors++;
            $display("FAIL vec4_const: D=%b B_out=%b O_sub=%b, required 0111 0 1",
                     bus.D, bus.B_out, bus.O_sub);
        end
    endtask

    task automatic test_back_to_back();
        test_op(4'b0101, 4'b0011, 1, 1'b0, "ignore_busy");
        test_op(4'b0011, 4'b0101, 0, 1'b1, "b2b");
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL after_done: done=%b busy=%b, required 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_rst_mid_shift();
        int done_seen;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 4'b0110;
        bus.B     = 4'b0001;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.D !== '0 ||
            bus.B_out !== 1'b0 || bus.O_sub !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: busy=%b done=%b D=%b B_out=%b O_sub=%b, required all zero",
                     bus.busy, bus.done, bus.D, bus.B_out, bus.O_sub);
        end
        done_seen = 0;
        for (int i = 0; i < int'(W) + 2; i++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
            @(negedge clk);
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL rst_no_done: activity cycles=%0d, required 0", done_seen);
        end
        exp_d_last = '0;
        exp_b_last = 1'b0;
        exp_o_last = 1'b0;
        // Reset and start asserted together: reset wins.
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.A     = 4'b0110;
        bus.B     = 4'b0001;
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_priority: busy=%b, required 0", bus.busy);
        end
        test_op(4'b0110, 4'b0001, 0, 1'b0, "after_rst");
    endtask

    task automatic test_equal();
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] v;
            v = W'($urandom);
            test_op(v, v, 0, 1'b0, "equal");
        end
        test_op(4'b1000, 4'b1000, 0, 1'b0, "equal_min");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            test_op(W'($urandom), W'($urandom), 2, ($urandom_range(0, 1) == 1), "random");
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_rst_mid_shift();
        test_equal();
        test_random();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
